riscv_ahb3lite_master_merge: RTL and testbench

Two-to-one AHB3-Lite master merge for the RV12 subsystem. It sits directly downstream of the core top level. It takes the separate instruction (`ins_*`) and data (`dat_*`) master ports and drives one shared AHB3-Lite master port, which feeds a single-port interconnect or memory. The two core masters have no grant signal, so the block stalls the losing master through its HREADY and holds that master's address phase in a per-port pending register until the shared bus accepts it.

---
 rtl/riscv_ahb3lite_master_merge.sv | 159 +++++++++++++++
 tb/tb_riscv_ahb3lite_master_merge.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_ahb3lite_master_merge.sv
// Two-to-one AHB3-Lite master merge: instruction and data core masters share one bus.
// The losing master is stalled via its HREADY and its address phase is parked in a pending register.
module riscv_ahb3lite_master_merge #(
    parameter int XLEN = 32,
    parameter int PLEN = XLEN
) (
    input  logic            HRESETn,
    input  logic            HCLK,

    input  logic            ins_HSEL,
    input  logic [PLEN-1:0] ins_HADDR,
    input  logic [XLEN-1:0] ins_HWDATA,
    output logic [XLEN-1:0] ins_HRDATA,
    input  logic            ins_HWRITE,
    input  logic [2:0]      ins_HSIZE,
    input  logic [2:0]      ins_HBURST,
    input  logic [3:0]      ins_HPROT,
    input  logic [1:0]      ins_HTRANS,
    input  logic            ins_HMASTLOCK,
    output logic            ins_HREADY,
    output logic            ins_HRESP,

    input  logic            dat_HSEL,
    input  logic [PLEN-1:0] dat_HADDR,
    input  logic [XLEN-1:0] dat_HWDATA,
    output logic [XLEN-1:0] dat_HRDATA,
    input  logic            dat_HWRITE,
    input  logic [2:0]      dat_HSIZE,
    input  logic [2:0]      dat_HBURST,
    input  logic [3:0]      dat_HPROT,
    input  logic [1:0]      dat_HTRANS,
    input  logic            dat_HMASTLOCK,
    output logic            dat_HREADY,
    output logic            dat_HRESP,

    output logic            m_HSEL,
    output logic [PLEN-1:0] m_HADDR,
    output logic [XLEN-1:0] m_HWDATA,
    input  logic [XLEN-1:0] m_HRDATA,
    output logic            m_HWRITE,
    output logic [2:0]      m_HSIZE,
    output logic [2:0]      m_HBURST,
    output logic [3:0]      m_HPROT,
    output logic [1:0]      m_HTRANS,
    output logic            m_HMASTLOCK,
    input  logic            m_HREADY,
    input  logic            m_HRESP
);

    localparam logic       INS         = 1'b0;
    localparam logic       DAT         = 1'b1;
    localparam logic [1:0] HTRANS_IDLE = 2'b00;

    typedef struct packed {
        logic [PLEN-1:0] addr;
        logic            write;
        logic [2:0]      size;
        logic [2:0]      burst;
        logic [3:0]      prot;
        logic [1:0]      trans;
        logic            lock;
    } addr_phase_t;

    addr_phase_t [1:0] live;
    addr_phase_t [1:0] pend_ap_q;
    addr_phase_t       sel;

    logic [1:0] pend_q, pend_d;
    logic [1:0] xready, live_req, req, issue;
    logic       owner_q, owner_d, owner_hold;
    logic       downer_q, dvalid_q, lock_q;

    always_comb begin
        live[INS] = '{addr: ins_HADDR, write: ins_HWRITE, size: ins_HSIZE, burst: ins_HBURST,
                      prot: ins_HPROT, trans: ins_HTRANS, lock: ins_HMASTLOCK};
        live[DAT] = '{addr: dat_HADDR, write: dat_HWRITE, size: dat_HSIZE, burst: dat_HBURST,
                      prot: dat_HPROT, trans: dat_HTRANS, lock: dat_HMASTLOCK};
    end

    // A parked port is stalled; the data-phase owner sees the shared bus ready.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            xready[i]   = pend_q[i] ? 1'b0 : ((downer_q == 1'(i)) ? m_HREADY : 1'b1);
            live_req[i] = live[i].trans[1] & xready[i];
        end
    end

    assign req        = pend_q | live_req;
    assign owner_hold = lock_q | live[owner_q].trans[0];

    always_comb begin
        owner_d = owner_q;
        if (!owner_hold) begin
            if (req[DAT])      owner_d = DAT;
            else if (req[INS]) owner_d = INS;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            issue[i] = m_HREADY & (owner_d == 1'(i)) & req[i];
        end
        pend_d = (pend_q | live_req) & ~issue;
    end

    always_comb begin
        sel = pend_q[owner_d] ? pend_ap_q[owner_d] : live[owner_d];
        if (!sel.trans[1]) begin
            sel.trans = HTRANS_IDLE;
            sel.lock  = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_q   <= 2'b00;
            owner_q  <= DAT;
            downer_q <= DAT;
            dvalid_q <= 1'b0;
            lock_q   <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (m_HREADY) begin
                owner_q  <= owner_d;
                downer_q <= owner_d;
                dvalid_q <= m_HTRANS[1];
                lock_q   <= m_HMASTLOCK;
            end
        end
    end

    // NOTE: the parked payload needs no reset; it is only observed while its pend_q flag is set.
    always_ff @(posedge HCLK) begin
        for (int i = 0; i < 2; i++) begin
            if (live_req[i] && !issue[i]) pend_ap_q[i] <= live[i];
        end
    end

    assign m_HADDR     = sel.addr;
    assign m_HWRITE    = sel.write;
    assign m_HSIZE     = sel.size;
    assign m_HBURST    = sel.burst;
    assign m_HPROT     = sel.prot;
    assign m_HTRANS    = sel.trans;
    assign m_HMASTLOCK = sel.lock;
    assign m_HSEL      = sel.trans[1];
    assign m_HWDATA    = (downer_q == DAT) ? dat_HWDATA : ins_HWDATA;

    assign ins_HRDATA = m_HRDATA;
    assign dat_HRDATA = m_HRDATA;
    assign ins_HREADY = xready[INS];
    assign dat_HREADY = xready[DAT];
    assign ins_HRESP  = (downer_q == INS) ? m_HRESP : 1'b0;
    assign dat_HRESP  = (downer_q == DAT) ? m_HRESP : 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{ins_HSEL, dat_HSEL, dvalid_q};

endmodule

// File: tb/tb_riscv_ahb3lite_master_merge.sv
// Directed bench for the instruction/data AHB3-Lite merge; issued address phases are
// checked against a queue of expected transfers filled as stimulus is driven.
module tb_riscv_ahb3lite_master_merge;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    logic        HRESETn, HCLK;
    logic        ins_HSEL, dat_HSEL;
    logic [31:0] ins_HADDR, ins_HWDATA, ins_HRDATA;
    logic [31:0] dat_HADDR, dat_HWDATA, dat_HRDATA;
    logic        ins_HWRITE, dat_HWRITE;
    logic [2:0]  ins_HSIZE, ins_HBURST, dat_HSIZE, dat_HBURST;
    logic [3:0]  ins_HPROT, dat_HPROT;
    logic [1:0]  ins_HTRANS, dat_HTRANS;
    logic        ins_HMASTLOCK, dat_HMASTLOCK;
    logic        ins_HREADY, ins_HRESP, dat_HREADY, dat_HRESP;
    logic        m_HSEL;
    logic [31:0] m_HADDR, m_HWDATA, m_HRDATA;
    logic        m_HWRITE;
    logic [2:0]  m_HSIZE, m_HBURST;
    logic [3:0]  m_HPROT;
    logic [1:0]  m_HTRANS;
    logic        m_HMASTLOCK, m_HREADY, m_HRESP;

    riscv_ahb3lite_master_merge #(.XLEN(32), .PLEN(32)) dut (
        .HRESETn(HRESETn), .HCLK(HCLK),
        .ins_HSEL(ins_HSEL), .ins_HADDR(ins_HADDR), .ins_HWDATA(ins_HWDATA), .ins_HRDATA(ins_HRDATA),
        .ins_HWRITE(ins_HWRITE), .ins_HSIZE(ins_HSIZE), .ins_HBURST(ins_HBURST), .ins_HPROT(ins_HPROT),
        .ins_HTRANS(ins_HTRANS), .ins_HMASTLOCK(ins_HMASTLOCK), .ins_HREADY(ins_HREADY), .ins_HRESP(ins_HRESP),
        .dat_HSEL(dat_HSEL), .dat_HADDR(dat_HADDR), .dat_HWDATA(dat_HWDATA), .dat_HRDATA(dat_HRDATA),
        .dat_HWRITE(dat_HWRITE), .dat_HSIZE(dat_HSIZE), .dat_HBURST(dat_HBURST), .dat_HPROT(dat_HPROT),
        .dat_HTRANS(dat_HTRANS), .dat_HMASTLOCK(dat_HMASTLOCK), .dat_HREADY(dat_HREADY), .dat_HRESP(dat_HRESP),
        .m_HSEL(m_HSEL), .m_HADDR(m_HADDR), .m_HWDATA(m_HWDATA), .m_HRDATA(m_HRDATA),
        .m_HWRITE(m_HWRITE), .m_HSIZE(m_HSIZE), .m_HBURST(m_HBURST), .m_HPROT(m_HPROT),
        .m_HTRANS(m_HTRANS), .m_HMASTLOCK(m_HMASTLOCK), .m_HREADY(m_HREADY), .m_HRESP(m_HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [1:0] t, input logic w);
        exp_q.push_back('{addr: a, trans: t, write: w});
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic ins_drv(input logic [1:0] t, input logic [31:0] a, input logic [2:0] b);
        ins_HTRANS = t;
        ins_HADDR  = a;
        ins_HBURST = b;
    endtask

    task automatic dat_drv(input logic [1:0] t, input logic [31:0] a, input logic w,
                           input logic [2:0] b, input logic lk);
        dat_HTRANS    = t;
        dat_HADDR     = a;
        dat_HWRITE    = w;
        dat_HBURST    = b;
        dat_HMASTLOCK = lk;
    endtask

    // Every transfer accepted by the shared bus must be the next one the stimulus expects.
    always @(negedge HCLK) begin
        if (HRESETn && m_HREADY && m_HTRANS[1]) begin
            if (exp_q.size() == 0) begin
                check("unexpected_issue", {32'd0, m_HADDR}, 64'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("issue_order", 64'({m_HADDR, m_HTRANS, m_HWRITE}), 64'(e));
            end
        end
    end

    initial begin
        HRESETn = 1'b0;
        ins_HSEL = 1'b0; dat_HSEL = 1'b0;
        ins_HWRITE = 1'b0; ins_HSIZE = 3'b010; ins_HPROT = 4'b0011; ins_HMASTLOCK = 1'b0;
        dat_HSIZE = 3'b010; dat_HPROT = 4'b0011;
        ins_HWDATA = 32'h1515_1515; dat_HWDATA = 32'hD0D0_D0D0;
        ins_drv(IDLE, 32'h0, 3'b000);
        dat_drv(IDLE, 32'h0, 1'b0, 3'b000, 1'b0);
        m_HREADY = 1'b1; m_HRESP = 1'b0; m_HRDATA = 32'h0;

        #12;
        check("rst_m_htrans", 64'(m_HTRANS), 64'(IDLE));
        check("rst_m_hsel", 64'(m_HSEL), 64'd0);
        check("rst_ins_hready", 64'(ins_HREADY), 64'd1);
        check("rst_dat_hready", 64'(dat_HREADY), 64'd1);
        check("rst_hresp", 64'({ins_HRESP, dat_HRESP}), 64'd0);
        #1 HRESETn = 1'b1;

        // Single instruction read passes straight through
        cyc();
        ins_drv(NONSEQ, 32'h200, 3'b000); push(32'h200, NONSEQ, 1'b0);
        #1;
        check("single_addr", 64'(m_HADDR), 64'h200);
        check("single_trans", 64'(m_HTRANS), 64'(NONSEQ));
        check("single_hsel", 64'(m_HSEL), 64'd1);
        check("single_dat_rdy", 64'(dat_HREADY), 64'd1);
        cyc();
        ins_drv(IDLE, 32'h0, 3'b000); m_HRDATA = 32'hCAFE_0200; m_HREADY = 1'b0;
        #1;
        check("single_rdata", 64'(ins_HRDATA), 64'hCAFE_0200);
        check("single_ins_rdy_wait", 64'(ins_HREADY), 64'd0);
        check("single_dat_rdy2", 64'(dat_HREADY), 64'd1);
        cyc();
        m_HREADY = 1'b1;
        #1;
        check("single_ins_rdy_done", 64'(ins_HREADY), 64'd1);

        // Simultaneous requests: data first, instruction from the pending register
        cyc();
        ins_drv(NONSEQ, 32'h204, 3'b000);
        dat_drv(NONSEQ, 32'h1000, 1'b0, 3'b000, 1'b0);
        push(32'h1000, NONSEQ, 1'b0); push(32'h204, NONSEQ, 1'b0);
        #1;
        check("simul_addr0", 64'(m_HADDR), 64'h1000);
        check("simul_ins_rdy0", 64'(ins_HREADY), 64'd1);
        cyc();
        ins_drv(IDLE, 32'h0, 3'b000); dat_drv(IDLE, 32'h0, 1'b0, 3'b000, 1'b0);
        #1;
        check("simul_addr1", 64'(m_HADDR), 64'h204);
        check("simul_trans1", 64'(m_HTRANS), 64'(NONSEQ));
        check("simul_ins_rdy1", 64'(ins_HREADY), 64'd0);
        check("simul_wdata_dat", 64'(m_HWDATA), 64'hD0D0_D0D0);
        cyc();
        #1;
        check("simul_ins_rdy2", 64'(ins_HREADY), 64'd1);
        check("simul_wdata_ins", 64'(m_HWDATA), 64'h1515_1515);
        check("simul_idle", 64'(m_HTRANS), 64'(IDLE));

        // Data INCR4 burst holds the bus against a parked instruction fetch
        cyc();
        dat_drv(NONSEQ, 32'h2000, 1'b0, 3'b011, 1'b0);
        ins_drv(NONSEQ, 32'h300, 3'b000);
        push(32'h2000, NONSEQ, 1'b0);
        for (int b = 1; b < 4; b++) push(32'h2000 + 32'(4 * b), SEQ, 1'b0);
        push(32'h300, NONSEQ, 1'b0);
        #1;
        check("burst_beat0", 64'(m_HADDR), 64'h2000);
        for (int b = 1; b < 4; b++) begin
            cyc();
            ins_drv(IDLE, 32'h0, 3'b000);
            dat_drv(SEQ, 32'h2000 + 32'(4 * b), 1'b0, 3'b011, 1'b0);
            #1;
            check("burst_beat", 64'(m_HADDR), 64'(32'h2000 + 32'(4 * b)));
            check("burst_ins_stall", 64'(ins_HREADY), 64'd0);
        end
        cyc();
        dat_drv(IDLE, 32'h0, 1'b0, 3'b000, 1'b0);
        #1;
        check("burst_then_ins", 64'({m_HADDR, m_HTRANS}), 64'({32'h300, NONSEQ}));
        cyc();
        #1;
        check("burst_ins_rdy", 64'(ins_HREADY), 64'd1);

        // Instruction SEQ beat keeps ownership against a data request
        cyc();
        ins_drv(NONSEQ, 32'h500, 3'b001); push(32'h500, NONSEQ, 1'b0);
        #1;
        check("ibur_beat0", 64'(m_HADDR), 64'h500);
        cyc();
        ins_drv(SEQ, 32'h504, 3'b001);
        dat_drv(NONSEQ, 32'h1100, 1'b0, 3'b000, 1'b0);
        push(32'h504, SEQ, 1'b0); push(32'h1100, NONSEQ, 1'b0);
        #1;
        check("ibur_hold", 64'({m_HADDR, m_HTRANS}), 64'({32'h504, SEQ}));
        cyc();
        ins_drv(IDLE, 32'h0, 3'b000); dat_drv(IDLE, 32'h0, 1'b0, 3'b000, 1'b0);
        #1;
        check("ibur_dat_next", 64'(m_HADDR), 64'h1100);
        check("ibur_dat_stall", 64'(dat_HREADY), 64'd0);
        cyc();
        #1;
        check("ibur_dat_rdy", 64'(dat_HREADY), 64'd1);

        // Locked read-modify-write keeps the instruction port out until the unlock
        cyc();
        dat_drv(NONSEQ, 32'h40, 1'b0, 3'b000, 1'b1);
        ins_drv(NONSEQ, 32'h600, 3'b000);
        push(32'h40, NONSEQ, 1'b0); push(32'h40, NONSEQ, 1'b1); push(32'h600, NONSEQ, 1'b0);
        #1;
        check("lock_rd", 64'({m_HADDR, m_HMASTLOCK}), 64'({32'h40, 1'b1}));
        cyc();
        ins_drv(IDLE, 32'h0, 3'b000);
        dat_drv(NONSEQ, 32'h40, 1'b1, 3'b000, 1'b1);
        #1;
        check("lock_wr", 64'({m_HADDR, m_HWRITE}), 64'({32'h40, 1'b1}));
        check("lock_ins_stall", 64'(ins_HREADY), 64'd0);
        cyc();
        dat_drv(IDLE, 32'h0, 1'b0, 3'b000, 1'b0);
        #1;
        check("lock_release_idle", 64'({m_HTRANS, m_HMASTLOCK}), 64'({IDLE, 1'b0}));
        check("lock_ins_stall2", 64'(ins_HREADY), 64'd0);
        check("lock_wdata", 64'(m_HWDATA), 64'hD0D0_D0D0);
        cyc();
        #1;
        check("lock_ins_issue", 64'({m_HADDR, m_HTRANS}), 64'({32'h600, NONSEQ}));
        cyc();

        // Three wait states on a data read; instruction request is parked meanwhile
        cyc();
        dat_drv(NONSEQ, 32'h3000, 1'b0, 3'b000, 1'b0); push(32'h3000, NONSEQ, 1'b0);
        #1;
        check("wait_dat_addr", 64'(m_HADDR), 64'h3000);
        cyc();
        dat_drv(IDLE, 32'h0, 1'b0, 3'b000, 1'b0);
        ins_drv(NONSEQ, 32'h400, 3'b000); push(32'h400, NONSEQ, 1'b0);
        m_HREADY = 1'b0;
        #1;
        check("wait_ins_accept", 64'(ins_HREADY), 64'd1);
        check("wait_dat_stall", 64'(dat_HREADY), 64'd0);
        for (int w = 0; w < 2; w++) begin
            cyc();
            ins_drv(IDLE, 32'h0, 3'b000);
            #1;
            check("wait_ins_parked", 64'(ins_HREADY), 64'd0);
            check("wait_dat_stall_n", 64'(dat_HREADY), 64'd0);
        end
        cyc();
        m_HREADY = 1'b1;
        #1;
        check("wait_ins_issue", 64'({m_HADDR, m_HTRANS}), 64'({32'h400, NONSEQ}));
        check("wait_dat_done", 64'(dat_HREADY), 64'd1);
        cyc();
        #1;
        check("wait_ins_rdy", 64'(ins_HREADY), 64'd1);

        // Two-cycle ERROR on a data transfer is seen only by the data port
        cyc();
        dat_drv(NONSEQ, 32'h5000, 1'b0, 3'b000, 1'b0); push(32'h5000, NONSEQ, 1'b0);
        cyc();
        dat_drv(IDLE, 32'h0, 1'b0, 3'b000, 1'b0);
        m_HRESP = 1'b1; m_HREADY = 1'b0;
        #1;
        check("err1_resp", 64'({dat_HRESP, ins_HRESP}), 64'b10);
        check("err1_rdy", 64'({dat_HREADY, ins_HREADY}), 64'b01);
        cyc();
        m_HREADY = 1'b1;
        #1;
        check("err2_resp", 64'({dat_HRESP, ins_HRESP}), 64'b10);
        check("err2_rdy", 64'({dat_HREADY, ins_HREADY}), 64'b11);
        cyc();
        m_HRESP = 1'b0;
        #1;
        check("err_clear", 64'(dat_HRESP), 64'd0);

        // Asynchronous reset with the instruction port parked
        cyc();
        ins_drv(NONSEQ, 32'h700, 3'b000);
        dat_drv(NONSEQ, 32'h6000, 1'b0, 3'b000, 1'b0); push(32'h6000, NONSEQ, 1'b0);
        cyc();
        ins_drv(IDLE, 32'h0, 3'b000); dat_drv(IDLE, 32'h0, 1'b0, 3'b000, 1'b0);
        #1;
        check("rstmid_parked", 64'(ins_HREADY), 64'd0);
        HRESETn = 1'b0;
        #1;
        check("rstmid_ins_rdy", 64'(ins_HREADY), 64'd1);
        check("rstmid_idle", 64'({m_HTRANS, m_HSEL}), 64'({IDLE, 1'b0}));
        cyc();
        HRESETn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("rstmid_no_stale", 64'(m_HTRANS), 64'(IDLE));
            check("rstmid_rdy", 64'({ins_HREADY, dat_HREADY}), 64'b11);
        end

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
